alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute stage directly downstream of ALU control.
- Consumes the 7-bit ALU control word plus two operands, computes the result and the branch decision, and presents them through a valid/ready handshake.
- Shifts run iteratively in a dedicated shift sub-unit; all other ops complete in one cycle.
- Single-entry: holds one operation from accept until the result is consumed.

Parameters:
- WIDTH, 32, operand/result width.
- SHIFT_STEP, 1, bit positions shifted per cycle; legal values 1, 2, 4.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept.
- alu_ctl  input  7  control word: [6:4] branch condition, [3:0] op.
- slt_unsigned  input  1  SLT/SLTU select, driven from funct3[0] by decode.
- op_a  input  WIDTH  rs1 value.
- op_b  input  WIDTH  rs2, immediate or CSR value.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  computed value.
- branch_taken  output  1  branch condition true.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; out_valid=0, result=0, branch_taken=0, busy=0; any in-flight op is discarded.
- States and transitions:
  - IDLE -> DONE on accept of a non-shift op.
  - IDLE -> SHIFT on accept of a shift op.
  - SHIFT -> DONE when the remaining shift count reaches 0.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> DONE or SHIFT on out_ready with a simultaneous accept.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready; inputs are captured only on accept.
- Op codes (alu_ctl[3:0]):
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1000 XOR.
  - 0111 SLT: result = {0…, a<b}; signed when slt_unsigned=0, unsigned when 1.
  - 0101 SLL, 0011 SRL, 0100 SRA: shift amount = op_b[4:0]; SRA sign-fills.
  - 1001 CSRRW: result = op_a.
  - 1010 CSRRS: result = op_b | op_a.
  - 1011 CSRRC: result = op_b & ~op_a.
  - 1111 and all other codes: result = 0 (no-op; still handshakes).
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- Branch condition (alu_ctl[6:4]), evaluated at accept and latched with the result:
  - 001 EQ; 010 NE; 011 LT signed; 100 GE signed; 101 LTU; 110 GEU.
  - 000 and 111: branch_taken=0.
  - The result field is still computed from the op code (branch words carry SUB, 0110).
- Latency:
  - Non-shift op: out_valid rises on the edge after accept (1 cycle).
  - Shift op: out_valid rises ceil(shamt/SHIFT_STEP)+1 cycles after accept. shamt=0 gives latency 1; SHIFT is skipped and result = op_a.
  - Each SHIFT cycle shifts min(SHIFT_STEP, remaining) positions.
- Back-pressure: while out_valid=1 and out_ready=0, result and branch_taken hold stable and in_ready=0.
- Throughput: one op per cycle when out_ready is held high and all ops are non-shift.
- in_valid during SHIFT is ignored (not accepted); the upstream stage must hold it.
- out_valid is never high in IDLE or SHIFT.

Decomposition:
- Shared package alu_pkg:
  - op code constants: AND, OR, ADD, SRL, SRA, SLL, SUB, SLT, XOR, CSRRW, CSRRS, CSRRC, NOP.
  - branch condition constants: NONE, EQ, NE, LT, GE, LTU, GEU.
  - FSM state typedef: IDLE, SHIFT, DONE.
- The same op and condition constants are used by ALU control.
- One sub-module: alu_shift_unit.
  - Iterative shifter with load, direction, arithmetic flag, amount and done.
  - Owns its remaining-count register.

Test Plan:
- ADD: alu_ctl=0000010, a=5, b=7 -> out_valid on the edge after accept, result=12, branch_taken=0.
- SRA: alu_ctl=0000100, a=0x80000000, b=4, SHIFT_STEP=1 -> busy high 4 cycles, out_valid at cycle 5, result=0xF8000000. Repeat with b=0 -> result=0x80000000 at cycle 1.
- Branches:
  - BLT: alu_ctl=0110110, a=0xFFFFFFFF, b=1 -> branch_taken=1.
  - BGEU: alu_ctl=1100110, same operands -> branch_taken=1.
  - BEQ: alu_ctl=0010110, a=b=3 -> branch_taken=1, result=0.
- SLTU vs SLT: a=0xFFFFFFFF, b=1:
  - slt_unsigned=1 -> result=0.
  - slt_unsigned=0 -> result=1.
- Back-pressure: out_ready=0 for 3 cycles after XOR of 0xF0F0 and 0x0FF0 -> result=0xFF00 held stable, in_ready=0; then out_ready=1 with a new in_valid -> accepted the same cycle.
- Reset mid-shift: SLL with a=1, b=31; assert rst at cycle 10 -> next edge out_valid=0, result=0, busy=0, in_ready=1; no stale result afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for ALU control and the execute stage.
package alu_pkg;

    // Operation codes carried in alu_ctl[3:0]
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_SRA   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_CSRRW = 4'b1001;
    localparam logic [3:0] OP_CSRRS = 4'b1010;
    localparam logic [3:0] OP_CSRRC = 4'b1011;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    // Branch conditions carried in alu_ctl[6:4]
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_LT   = 3'b011;
    localparam logic [2:0] BR_GE   = 3'b100;
    localparam logic [2:0] BR_LTU  = 3'b101;
    localparam logic [2:0] BR_GEU  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: moves up to SHIFT_STEP positions per enabled cycle and
// keeps its own count of positions still to go.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dir_left,
    input  logic             arith,
    input  logic [4:0]       amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             step_en,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [4:0] STEP_AMT = 5'(SHIFT_STEP);

    logic [WIDTH-1:0] data_q, data_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;
    logic [4:0]       step_amt;
    logic [WIDTH-1:0] shifted;

    // One step of the shift; data_out is the value after this cycle's step so
    // the parent can capture the final value on the same edge the count empties.
    always_comb begin
        step_amt = (cnt_q < STEP_AMT) ? cnt_q : STEP_AMT;
        if (left_q) begin
            shifted = data_q << step_amt;
        end else if (arith_q) begin
            shifted = WIDTH'($signed(data_q) >>> step_amt);
        end else begin
            shifted = data_q >> step_amt;
        end
        done     = step_en && (cnt_q <= STEP_AMT);
        data_out = shifted;
    end

    // Next-state: load a fresh operation or advance the one in progress.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (load) begin
            data_d  = data_in;
            cnt_d   = amount;
            left_d  = dir_left;
            arith_d = arith;
        end else if (step_en && (cnt_q != 5'd0)) begin
            data_d = shifted;
            cnt_d  = cnt_q - step_amt;
        end
    end

    // Shifter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-entry execute stage: computes ALU result and branch decision,
// runs shifts through the iterative shifter, and hands off via valid/ready.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       alu_ctl,
    input  logic             slt_unsigned,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             branch_q, branch_d;

    logic [3:0]       op;
    logic [2:0]       cond;
    logic [4:0]       shamt;
    logic             accept;
    logic             slt_lt;
    logic             lt_s, lt_u, eq;
    logic [WIDTH-1:0] alu_value;
    logic             branch_cond;
    logic             shift_load;
    logic             shift_done;
    logic [WIDTH-1:0] shift_data;

    assign op        = alu_ctl[3:0];
    assign cond      = alu_ctl[6:4];
    assign shamt     = op_b[4:0];
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT);
    assign result    = result_q;
    assign branch_taken = branch_q;

    // Single-cycle result and branch decision from the presented operands.
    always_comb begin
        eq     = (op_a == op_b);
        lt_s   = ($signed(op_a) < $signed(op_b));
        lt_u   = (op_a < op_b);
        slt_lt = slt_unsigned ? lt_u : lt_s;
        unique case (op)
            OP_AND:   alu_value = op_a & op_b;
            OP_OR:    alu_value = op_a | op_b;
            OP_ADD:   alu_value = op_a + op_b;
            OP_SUB:   alu_value = op_a - op_b;
            OP_XOR:   alu_value = op_a ^ op_b;
            OP_SLT:   alu_value = {{(WIDTH-1){1'b0}}, slt_lt};
            // Only used when the shift amount is zero (no shifting needed).
            OP_SLL, OP_SRL, OP_SRA: alu_value = op_a;
            OP_CSRRW: alu_value = op_a;
            OP_CSRRS: alu_value = op_b | op_a;
            OP_CSRRC: alu_value = op_b & ~op_a;
            default:  alu_value = '0;
        endcase
        unique case (cond)
            BR_EQ:   branch_cond = eq;
            BR_NE:   branch_cond = !eq;
            BR_LT:   branch_cond = lt_s;
            BR_GE:   branch_cond = !lt_s;
            BR_LTU:  branch_cond = lt_u;
            BR_GEU:  branch_cond = !lt_u;
            default: branch_cond = 1'b0;
        endcase
    end

    // FSM next-state and captured outputs; a new accept overrides the drain.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        branch_d   = branch_q;
        shift_load = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d  = ST_DONE;
                    result_d = shift_data;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            branch_d = branch_cond;
            if (is_shift_op(op) && (shamt != 5'd0)) begin
                state_d    = ST_SHIFT;
                shift_load = 1'b1;
            end else begin
                state_d  = ST_DONE;
                result_d = alu_value;
            end
        end
    end

    // State, result and branch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    alu_shift_unit #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (shift_load),
        .dir_left (op == OP_SLL),
        .arith    (op == OP_SRA),
        .amount   (shamt),
        .data_in  (op_a),
        .step_en  (state_q == ST_SHIFT),
        .done     (shift_done),
        .data_out (shift_data)
    );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit against a behavioural reference model.
module tb_alu_exec_unit;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  alu_ctl;
    logic        slt_unsigned;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch_taken;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(STEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_ctl      (alu_ctl),
        .slt_unsigned (slt_unsigned),
        .op_a         (op_a),
        .op_b         (op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .busy         (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_result(input logic [6:0] ctl, input logic sltu,
                                                 input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        case (ctl[3:0])
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b1000: r = a ^ b;
            4'b0111: begin
                if (sltu) r = (a < b) ? 32'd1 : 32'd0;
                else      r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            4'b0101: r = a << sh;
            4'b0011: r = a >> sh;
            4'b0100: r = $signed(a) >>> sh;
            4'b1001: r = a;
            4'b1010: r = b | a;
            4'b1011: r = b & ~a;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic model_branch(input logic [6:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctl[6:4])
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return sa < sb;
            3'd4:    return sa >= sb;
            3'd5:    return a < b;
            3'd6:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_latency(input logic [6:0] ctl, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        if ((ctl[3:0] == 4'b0101 || ctl[3:0] == 4'b0011 || ctl[3:0] == 4'b0100) && sh != 0)
            return (sh + STEP - 1) / STEP + 1;
        return 1;
    endfunction

    // ---------------- driver ----------------
    // Issues one op from IDLE, waits (bounded) for out_valid, then consumes it.
    task automatic run_op(input logic [6:0] ctl, input logic sltu, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output logic br,
                          output int lat, output int busy_cycles);
        int cyc;
        alu_ctl = ctl; slt_unsigned = sltu; op_a = a; op_b = b;
        in_valid = 1'b1; out_ready = 1'b0;
        busy_cycles = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            cyc++;
        end
        lat = out_valid ? cyc : -1;
        res = result;
        br  = branch_taken;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctl = '0; slt_unsigned = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || branch_taken !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: out_valid=%b result=%h branch=%b busy=%b in_ready=%b required 0/0/0/0/1",
                     out_valid, result, branch_taken, busy, in_ready);
        end
        $display("reset: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
    endtask

    task automatic test_add();
        logic [31:0] r; logic br; int lat, bc;
        run_op(7'b0000010, 1'b0, 32'd5, 32'd7, r, br, lat, bc);
        checks++;
        if (r !== 32'd12 || br !== 1'b0 || lat !== 1) begin
            failures++;
            $display("FAIL add: result=%h br=%b lat=%0d required 0000000c/0/1", r, br, lat);
        end
        $display("add 5+7: result=%h br=%b lat=%0d", r, br, lat);
    endtask

    task automatic test_sra();
        logic [31:0] r; logic br; int lat, bc;
        run_op(7'b0000100, 1'b0, 32'h8000_0000, 32'd4, r, br, lat, bc);
        checks++;
        if (r !== 32'hF800_0000 || lat !== 5 || bc !== 4) begin
            failures++;
            $display("FAIL sra4: result=%h lat=%0d busy=%0d required f8000000/5/4", r, lat, bc);
        end
        $display("sra 4: result=%h lat=%0d busy_cycles=%0d", r, lat, bc);
        run_op(7'b0000100, 1'b0, 32'h8000_0000, 32'd0, r, br, lat, bc);
        checks++;
        if (r !== 32'h8000_0000 || lat !== 1 || bc !== 0) begin
            failures++;
            $display("FAIL sra0: result=%h lat=%0d busy=%0d required 80000000/1/0", r, lat, bc);
        end
        $display("sra 0: result=%h lat=%0d busy_cycles=%0d", r, lat, bc);
    endtask

    task automatic test_branches();
        logic [31:0] r; logic br; int lat, bc;
        run_op(7'b0110110, 1'b0, 32'hFFFF_FFFF, 32'd1, r, br, lat, bc);
        checks++;
        if (br !== 1'b1) begin
            failures++;
            $display("FAIL blt: branch=%b required 1", br);
        end
        $display("blt -1<1: branch=%b", br);
        run_op(7'b1100110, 1'b0, 32'hFFFF_FFFF, 32'd1, r, br, lat, bc);
        checks++;
        if (br !== 1'b1) begin
            failures++;
            $display("FAIL bgeu: branch=%b required 1", br);
        end
        $display("bgeu: branch=%b", br);
        run_op(7'b0010110, 1'b0, 32'd3, 32'd3, r, br, lat, bc);
        checks++;
        if (br !== 1'b1 || r !== 32'd0) begin
            failures++;
            $display("FAIL beq: branch=%b result=%h required 1/00000000", br, r);
        end
        $display("beq: branch=%b result=%h", br, r);
    endtask

    task automatic test_slt();
        logic [31:0] r; logic br; int lat, bc;
        run_op(7'b0000111, 1'b1, 32'hFFFF_FFFF, 32'd1, r, br, lat, bc);
        checks++;
        if (r !== 32'd0) begin
            failures++;
            $display("FAIL sltu: result=%h required 00000000", r);
        end
        $display("sltu: result=%h", r);
        run_op(7'b0000111, 1'b0, 32'hFFFF_FFFF, 32'd1, r, br, lat, bc);
        checks++;
        if (r !== 32'd1) begin
            failures++;
            $display("FAIL slt: result=%h required 00000001", r);
        end
        $display("slt: result=%h", r);
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, exp_r; logic br, exp_b; logic [6:0] ctl; logic sltu;
        int lat, bc, exp_l;
        for (int i = 0; i < 40; i++) begin
            ctl  = 7'($urandom_range(0, 127));
            sltu = 1'($urandom_range(0, 1));
            a    = $urandom();
            b    = $urandom();
            if ($urandom_range(0, 3) == 0) a = b;
            if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 9));
            exp_r = model_result(ctl, sltu, a, b);
            exp_b = model_branch(ctl, a, b);
            exp_l = model_latency(ctl, b);
            run_op(ctl, sltu, a, b, r, br, lat, bc);
            checks++;
            if (r !== exp_r || br !== exp_b || lat !== exp_l) begin
                failures++;
                $display("FAIL random[%0d] ctl=%b a=%h b=%h: result=%h br=%b lat=%0d required %h/%b/%0d",
                         i, ctl, a, b, r, br, lat, exp_r, exp_b, exp_l);
            end
            $display("random[%0d] ctl=%b a=%h b=%h -> result=%h br=%b lat=%0d", i, ctl, a, b, r, br, lat);
        end
    endtask

    task automatic test_back_pressure();
        logic ok;
        alu_ctl = 7'b0001000; slt_unsigned = 1'b0;
        op_a = 32'h0000_F0F0; op_b = 32'h0000_0FF0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        ok = 1'b1;
        // keep in_valid high with a different op to show it is not taken
        alu_ctl = 7'b0000010; op_a = 32'd100; op_b = 32'd23;
        for (int c = 0; c < 3; c++) begin
            if (out_valid !== 1'b1 || result !== 32'h0000_FF00 || in_ready !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL backpressure hold: out_valid=%b result=%h in_ready=%b required 1/0000ff00/0",
                     out_valid, result, in_ready);
        end
        $display("backpressure hold: result=%h in_ready=%b", result, in_ready);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure release in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd123) begin
            failures++;
            $display("FAIL backpressure next: out_valid=%b result=%h required 1/0000007b", out_valid, result);
        end
        $display("backpressure next op: out_valid=%b result=%h", out_valid, result);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r;
        logic [3:0] ops [8];
        logic [6:0] ctl;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b0111, 4'b1010, 4'b1011};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ctl = {3'($urandom_range(0, 7)), ops[$urandom_range(0, 7)]};
            alu_ctl = ctl; slt_unsigned = 1'($urandom_range(0, 1));
            op_a = $urandom(); op_b = $urandom();
            in_valid = 1'b1;
            exp_r = model_result(ctl, slt_unsigned, op_a, op_b);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== exp_r || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b[%0d]: out_valid=%b result=%h in_ready=%b required 1/%h/1",
                         i, out_valid, result, in_ready, exp_r);
            end
            $display("b2b[%0d] ctl=%b -> result=%h", i, ctl, result);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b drain: out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic stale;
        alu_ctl = 7'b0000101; slt_unsigned = 1'b0; op_a = 32'd1; op_b = 32'd31;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midshift busy=%b required 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midshift reset: out_valid=%b result=%h busy=%b in_ready=%b required 0/0/0/1",
                     out_valid, result, busy, in_ready);
        end
        $display("reset mid-shift: out_valid=%b result=%h busy=%b", out_valid, result, busy);
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("FAIL midshift stale: out_valid or busy rose after reset, required 0");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sra();
        test_branches();
        test_slt();
        test_random();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
